// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and control priority decode for the fetch PC
package if_pkg;

  localparam int PCW_DEFAULT = 16;

  typedef logic [PCW_DEFAULT-1:0] pc_t;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_RET,
    OP_CALL,
    OP_ABS,
    OP_REL,
    OP_INC
  } pc_op_e;

  // Halt > Ret > Call > Abs_Jump > Rel_Jump > advance; a Call alongside a Ret is dropped.
  function automatic pc_op_e decode_op(input logic halt, input logic ret,
                                       input logic call, input logic abs_jump,
                                       input logic rel_jump);
    pc_op_e op;
    if (halt)          op = OP_HOLD;
    else if (ret)      op = OP_RET;
    else if (call)     op = OP_CALL;
    else if (abs_jump) op = OP_ABS;
    else if (rel_jump) op = OP_REL;
    else               op = OP_INC;
    return op;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack with saturating occupancy count
module ras_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         Reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty,
  output logic         overflow,
  output logic         underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] top;
  logic [AW:0]   count;

  // top addresses the next free slot; on overflow it wraps onto the oldest entry.
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign top_data  = mem[top - AW'(1)];
  assign overflow  = push & ~pop & full;
  assign underflow = pop & empty;

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      top   <= '0;
      count <= '0;
    end else if (pop) begin
      if (!empty) begin
        top   <= top - AW'(1);
        count <= count - (AW+1)'(1);
      end
    end else if (push) begin
      top <= top + AW'(1);
      if (!full) count <= count + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset_n && push && !pop) mem[top] <= push_data;
  end

endmodule

// File: rtl/if_ras_pc.sv
// rtl/if_ras_pc.sv - fetch program counter with jumps and a hardware return-address stack
module if_ras_pc
  import if_pkg::*;
#(
  parameter int             PCW       = 16,
  parameter int             RAS_DEPTH = 4,
  parameter logic [PCW-1:0] RESET_PC  = '0
) (
  input  logic           CLK,
  input  logic           Reset_n,
  input  logic           Halt,
  input  logic           Abs_Jump,
  input  logic           Rel_Jump,
  input  logic           Call,
  input  logic           Ret,
  input  logic [PCW-1:0] Offset,
  output logic [PCW-1:0] PC,
  output logic           Ras_Full,
  output logic           Ras_Empty,
  output logic           Ras_Err
);

  pc_op_e         op;
  logic [PCW-1:0] pc_inc;
  logic [PCW-1:0] pc_next;
  logic [PCW-1:0] ras_top;
  logic           ras_push;
  logic           ras_pop;
  logic           ras_ovf;
  logic           ras_udf;

  assign op       = decode_op(Halt, Ret, Call, Abs_Jump, Rel_Jump);
  assign pc_inc   = PC + PCW'(1);
  assign ras_push = (op == OP_CALL);
  assign ras_pop  = (op == OP_RET);

  ras_stack #(
    .W     (PCW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .full      (Ras_Full),
    .empty     (Ras_Empty),
    .overflow  (ras_ovf),
    .underflow (ras_udf)
  );

  // An underflowing Ret falls through to the sequential address.
  always_comb begin
    pc_next = pc_inc;
    case (op)
      OP_HOLD: pc_next = PC;
      OP_RET:  pc_next = Ras_Empty ? pc_inc : ras_top;
      OP_CALL: pc_next = Offset;
      OP_ABS:  pc_next = Offset;
      OP_REL:  pc_next = PC + Offset;
      default: pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      PC      <= RESET_PC;
      Ras_Err <= 1'b0;
    end else begin
      PC      <= pc_next;
      Ras_Err <= Ras_Err | ras_ovf | ras_udf;
    end
  end

endmodule

// File: tb/tb_if_ras_pc.sv
// tb/tb_if_ras_pc.sv - vector table and scoreboard bench for if_ras_pc
module tb_if_ras_pc;

  localparam int PCW = 16;

  logic           CLK = 1'b0;
  logic           Reset_n;
  logic           Halt;
  logic           Abs_Jump;
  logic           Rel_Jump;
  logic           Call;
  logic           Ret;
  logic [PCW-1:0] Offset;
  logic [PCW-1:0] PC;
  logic           Ras_Full;
  logic           Ras_Empty;
  logic           Ras_Err;

  typedef struct {
    logic           rst_n;
    logic           halt;
    logic           call;
    logic           ret;
    logic           abs_j;
    logic           rel_j;
    logic [PCW-1:0] off;
    logic [PCW-1:0] pc;
    logic           full;
    logic           empty;
    logic           err;
  } vec_t;

  vec_t table_q[$];
  vec_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  if_ras_pc #(.PCW(PCW), .RAS_DEPTH(4), .RESET_PC('0)) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .Halt      (Halt),
    .Abs_Jump  (Abs_Jump),
    .Rel_Jump  (Rel_Jump),
    .Call      (Call),
    .Ret       (Ret),
    .Offset    (Offset),
    .PC        (PC),
    .Ras_Full  (Ras_Full),
    .Ras_Empty (Ras_Empty),
    .Ras_Err   (Ras_Err)
  );

  always #5 CLK = ~CLK;

  task automatic add(input logic rst_n, input logic halt, input logic call,
                     input logic ret, input logic abs_j, input logic rel_j,
                     input logic [PCW-1:0] off, input logic [PCW-1:0] pc,
                     input logic full, input logic empty, input logic err);
    vec_t v;
    v.rst_n = rst_n; v.halt = halt; v.call = call; v.ret = ret;
    v.abs_j = abs_j; v.rel_j = rel_j; v.off = off;
    v.pc = pc; v.full = full; v.empty = empty; v.err = err;
    table_q.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [PCW-1:0] act,
                     input logic [PCW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    Reset_n  = v.rst_n;
    Halt     = v.halt;
    Call     = v.call;
    Ret      = v.ret;
    Abs_Jump = v.abs_j;
    Rel_Jump = v.rel_j;
    Offset   = v.off;
    sb_q.push_back(v);
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard step %0d: got empty queue expected an entry", idx);
    end else begin
      e = sb_q.pop_front();
      chk("pc",    idx, PC,                 e.pc);
      chk("full",  idx, {15'd0, Ras_Full},  {15'd0, e.full});
      chk("empty", idx, {15'd0, Ras_Empty}, {15'd0, e.empty});
      chk("err",   idx, {15'd0, Ras_Err},   {15'd0, e.err});
    end
  endtask

  task automatic one(input logic rst_n, input logic halt, input logic call,
                     input logic ret, input logic abs_j, input logic rel_j,
                     input logic [PCW-1:0] off, input logic [PCW-1:0] pc,
                     input logic full, input logic empty, input logic err,
                     input int idx);
    vec_t v;
    v.rst_n = rst_n; v.halt = halt; v.call = call; v.ret = ret;
    v.abs_j = abs_j; v.rel_j = rel_j; v.off = off;
    v.pc = pc; v.full = full; v.empty = empty; v.err = err;
    step(v, idx);
  endtask

  initial begin
    Reset_n = 1'b0; Halt = 1'b0; Call = 1'b0; Ret = 1'b0;
    Abs_Jump = 1'b0; Rel_Jump = 1'b0; Offset = '0;

    //  rst hlt cal ret abs rel  off       pc        full empty err
    // reset then sequential advance
    add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0002, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0003, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0004, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0005, 0, 1, 0);
    // single call / return from PC=5
    add(1, 0, 1, 0, 0, 0, 16'h0040, 16'h0040, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0041, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0042, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0043, 0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0006, 0, 1, 0);
    // nested calls with overflow, then LIFO returns and underflow
    add(1, 0, 1, 0, 0, 0, 16'h0010, 16'h0010, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 16'h0020, 16'h0020, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 16'h0030, 16'h0030, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 16'h0040, 16'h0040, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, 16'h0050, 16'h0050, 1, 0, 1);
    add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0041, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0031, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0021, 0, 0, 1);
    add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0011, 0, 1, 1);
    add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0012, 0, 1, 1);
    // reset clears the sticky error; negative relative jump wraps
    add(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0001, 0, 1, 0);
    add(1, 0, 0, 0, 0, 1, 16'hFFFD, 16'hFFFE, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 1, 0);
    // call at the top of memory pushes 0
    add(1, 0, 1, 0, 0, 0, 16'h0080, 16'h0080, 0, 0, 0);
    // halt freezes everything even with call/ret asserted
    add(1, 1, 1, 0, 0, 0, 16'h0099, 16'h0080, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 16'h0000, 16'h0080, 0, 0, 0);
    add(1, 1, 1, 1, 1, 0, 16'h0077, 16'h0080, 0, 0, 0);
    // call+ret: ret wins, no error
    add(1, 0, 1, 1, 0, 0, 16'h0055, 16'h0000, 0, 1, 0);
    // underflow at 0x20; error stays set
    add(1, 0, 0, 0, 1, 0, 16'h0020, 16'h0020, 0, 1, 0);
    add(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0021, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0022, 0, 1, 1);
    add(1, 1, 0, 0, 0, 0, 16'h0000, 16'h0022, 0, 1, 1);
    add(1, 0, 0, 0, 1, 1, 16'h0100, 16'h0100, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1, 16'h0010, 16'h0110, 0, 1, 1);

    for (int i = 0; i < table_q.size(); i++) step(table_q[i], i);

    // reset mid call chain, then the next Ret must underflow
    one(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 100);
    one(1, 0, 1, 0, 0, 0, 16'h0030, 16'h0030, 0, 0, 0, 101);
    one(1, 0, 1, 0, 0, 0, 16'h0040, 16'h0040, 0, 0, 0, 102);
    one(0, 0, 1, 1, 1, 0, 16'h0060, 16'h0000, 0, 1, 0, 103);
    one(1, 0, 0, 1, 0, 0, 16'h0000, 16'h0001, 0, 1, 1, 104);
    one(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0002, 0, 1, 1, 105);

    if (sb_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard drain: got %0d left expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
